// File: rtl/key_debounce.sv
// ============================================================================
// Module      : key_debounce
// Description : Two-key synchroniser/debouncer with clean levels and one-cycle
//               press/release pulses. Optional auto-repeat: KEY_REPEAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int REPEAT_DELAY    = 25000000,
   parameter int REPEAT_PERIOD   = 5000000
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       key0,
   input  logic       key1,
   output logic [1:0] key_level,
   output logic [1:0] key_press,
   output logic [1:0] key_release,
   output logic       any_press
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_param_check
      $error("key_debounce: cycle parameters must be >= 2");
   end

   logic [1:0] r_sync1;
   logic [1:0] r_sync2;

   // Keys are active-low; invert at the synchroniser so 1 means pressed.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= ~{key1, key0};
         r_sync2 <= r_sync1;
      end
   end

   for (genvar gi = 0; gi < 2; gi++) begin : g_key
      logic [CNT_W-1:0] r_cnt;
      logic             r_level;
      logic             r_press;
      logic             r_release;
      logic             w_s;
      logic             w_accept;
      logic             w_rep_hit;

      assign w_s      = r_sync2[gi];
      assign w_accept = (w_s != r_level) && (r_cnt == C_CNT_LAST);

`ifdef KEY_REPEAT_EN
      localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
      localparam int REP_W   = $clog2(REP_MAX + 1);
      localparam logic [REP_W-1:0] C_DLY_LAST = REP_W'(REPEAT_DELAY - 1);
      localparam logic [REP_W-1:0] C_PER_LAST = REP_W'(REPEAT_PERIOD - 1);

      logic [REP_W-1:0] r_rep;
      logic             r_rep_periodic;

      // A release accept takes priority so a pending repeat is never emitted.
      assign w_rep_hit = r_level && !w_accept &&
                         (r_rep == (r_rep_periodic ? C_PER_LAST : C_DLY_LAST));

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            r_rep          <= '0;
            r_rep_periodic <= 1'b0;
         end else if (!r_level || w_accept || w_rep_hit) begin
            r_rep          <= '0;
            r_rep_periodic <= w_rep_hit;
         end else begin
            r_rep          <= r_rep + 1'b1;
         end
      end
`else
      assign w_rep_hit = 1'b0;
`endif

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
         end else begin
            r_press   <= w_rep_hit;
            r_release <= 1'b0;
            if (w_s == r_level) begin
               r_cnt <= '0;
            end else if (!w_accept) begin
               r_cnt <= r_cnt + 1'b1;
            end else begin
               r_level   <= w_s;
               r_cnt     <= '0;
               r_press   <= w_s;
               r_release <= ~w_s;
            end
         end
      end

      assign key_level[gi]   = r_level;
      assign key_press[gi]   = r_press;
      assign key_release[gi] = r_release;
   end

   assign any_press = |key_press;

endmodule

`default_nettype wire

// File: tb/tb_key_debounce.sv
// ============================================================================
// Module      : tb_key_debounce
// Description : Directed bench for key_debounce (DEBOUNCE_CYCLES=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_key_debounce;

   logic       clk     = 1'b0;
   logic       reset_n = 1'b0;
   logic       key0    = 1'b1;
   logic       key1    = 1'b1;
   logic [1:0] key_level;
   logic [1:0] key_press;
   logic [1:0] key_release;
   logic       any_press;
   logic [6:0] w_outs;

   int n_checks = 0;
   int n_fail   = 0;

   key_debounce #(
      .DEBOUNCE_CYCLES(4),
      .REPEAT_DELAY   (10),
      .REPEAT_PERIOD  (3)
   ) u_dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .key0       (key0),
      .key1       (key1),
      .key_level  (key_level),
      .key_press  (key_press),
      .key_release(key_release),
      .any_press  (any_press)
   );

   always #5 clk = ~clk;

   assign w_outs = {key_level, key_press, key_release, any_press};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      // 1: reset and idle
      tick(3);
      chk("t1_reset_outs", w_outs, 0);
      reset_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         chk("t1_idle_outs", w_outs, 0);
      end

      // 2: key0 press latency and release
      key0 = 1'b0;
      tick(5);
      chk("t2_pre_level", key_level, 0);
      chk("t2_pre_press", key_press, 0);
      tick();
      chk("t2_level", key_level, 2'b01);
      chk("t2_press", key_press, 2'b01);
      chk("t2_any", any_press, 1);
      tick();
      chk("t2_press_end", key_press, 0);
      chk("t2_level_hold", key_level, 2'b01);
      tick(22);
      key0 = 1'b1;
      tick(5);
      chk("t2_rel_pre_level", key_level, 2'b01);
      chk("t2_rel_pre", key_release, 0);
      tick();
      chk("t2_release", key_release, 2'b01);
      chk("t2_rel_level", key_level, 0);
      tick();
      chk("t2_release_end", key_release, 0);

      // 3: key1 bounce shorter than the debounce window
      tick(5);
      for (int r = 0; r < 5; r++) begin
         key1 = 1'b0;
         for (int j = 0; j < 3; j++) begin
            tick();
            chk("t3_glitch_low", w_outs, 0);
         end
         key1 = 1'b1;
         for (int j = 0; j < 2; j++) begin
            tick();
            chk("t3_glitch_high", w_outs, 0);
         end
      end
      tick(6);
      chk("t3_settled", w_outs, 0);

      // 4: both keys together
      key0 = 1'b0;
      key1 = 1'b0;
      tick(5);
      chk("t4_pre_press", key_press, 0);
      tick();
      chk("t4_press", key_press, 2'b11);
      chk("t4_any", any_press, 1);
      chk("t4_level", key_level, 2'b11);
      tick();
      chk("t4_press_end", key_press, 0);
      chk("t4_any_end", any_press, 0);
      key0 = 1'b1;
      key1 = 1'b1;
      tick(6);
      chk("t4_release", key_release, 2'b11);
      tick();
      chk("t4_rel_level", key_level, 0);
      chk("t4_rel_end", key_release, 0);

      // 5: reset in the middle of a count, key held through release
      tick(3);
      key0 = 1'b0;
      tick(4);
      reset_n = 1'b0;
      #1;
      chk("t5_async_reset", w_outs, 0);
      tick(5);
      chk("t5_in_reset", w_outs, 0);
      reset_n = 1'b1;
      tick(5);
      chk("t5_pre_press", key_press, 0);
      chk("t5_pre_level", key_level, 0);
      tick();
      chk("t5_press", key_press, 2'b01);
      chk("t5_level", key_level, 2'b01);
      tick();
      chk("t5_press_end", key_press, 0);

      // 6: long hold, auto-repeat only when enabled
      key0 = 1'b1;
      tick(8);
      chk("t6_idle_level", key_level, 0);
      key0 = 1'b0;
      tick(6);
      chk("t6_press", key_press, 2'b01);
      for (int k = 1; k <= 30; k++) begin
         logic exp_rep;
`ifdef KEY_REPEAT_EN
         exp_rep = (k >= 10) && (((k - 10) % 3) == 0);
`else
         exp_rep = 1'b0;
`endif
         tick();
         chk("t6_repeat", key_press[0], exp_rep);
         chk("t6_repeat_any", any_press, exp_rep);
      end
      key0 = 1'b1;
      tick(8);
      chk("t6_released", key_level, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule

`default_nettype wire
